// File: rtl/apb_slave_mem.sv
// APB completer serving a word-addressed register memory with programmable wait states.
// Optional feature macro APB_SLV_ERR_EN: drives Pslverr and makes the last word a read-only ID register.
module apb_slave_mem #(
    parameter int          SEL_INDEX   = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          DEPTH       = 16,
    parameter int          WAIT_STATES = 0
) (
    input  logic        Hclk,
    input  logic        Hreset,
    input  logic [2:0]  Pselx,
    input  logic        Penable,
    input  logic        Pwrite,
    input  logic [31:0] Paddr,
    input  logic [31:0] Pwdata,
    output logic [31:0] Prdata,
    output logic        Pready,
    output logic        Pslverr
);

    localparam int         IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

`ifdef APB_SLV_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    // With error reporting enabled the last word carries a fixed ID value.
    function automatic logic [31:0] mem_reset_value(input int i);
        if (ERR_EN && (i == DEPTH - 1)) begin
            return 32'hA5A5_0000 | 32'(DEPTH);
        end else begin
            return 32'h0000_0000;
        end
    endfunction

    state_t           state_r;
    logic [3:0]       cnt_r;
    logic [IDX_W-1:0] idx_r;
    logic             write_r;
    logic [31:0]      wdata_r;
    logic             err_r;
    logic [31:0]      prdata_r;
    logic             pready_r;
    logic             pslverr_r;
    logic [31:0]      mem_r [DEPTH];

    logic             sel_s;
    logic             setup_s;
    logic [32:0]      paddr_ext_s;
    logic [32:0]      base_ext_s;
    logic             in_range_s;
    logic [IDX_W-1:0] idx_s;
    logic             err_s;
    logic             unused_sel_s;

    // 33-bit window compare so a window near the top of the map cannot wrap.
    assign sel_s        = Pselx[SEL_INDEX];
    assign setup_s      = sel_s & ~Penable;
    assign paddr_ext_s  = {1'b0, Paddr};
    assign base_ext_s   = {1'b0, BASE_ADDR};
    assign in_range_s   = (paddr_ext_s >= base_ext_s) &&
                          (paddr_ext_s < (base_ext_s + 33'(4 * DEPTH)));
    assign idx_s        = IDX_W'((Paddr - BASE_ADDR) >> 2);
    assign err_s        = ~in_range_s | (ERR_EN & Pwrite & (idx_s == LAST_IDX));
    assign unused_sel_s = ^Pselx;

    // Transfer FSM, memory array and registered APB response.
    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            state_r   <= IDLE;
            cnt_r     <= 4'd0;
            idx_r     <= '0;
            write_r   <= 1'b0;
            wdata_r   <= 32'h0000_0000;
            err_r     <= 1'b0;
            prdata_r  <= 32'h0000_0000;
            pready_r  <= 1'b0;
            pslverr_r <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= mem_reset_value(i);
            end
        end else if (setup_s) begin
            // A SETUP restarts the transfer whether we were idle or mid-access.
            state_r   <= ACCESS;
            cnt_r     <= WAIT_INIT;
            idx_r     <= idx_s;
            write_r   <= Pwrite;
            wdata_r   <= Pwdata;
            err_r     <= err_s;
            pready_r  <= (WAIT_INIT == 4'd0);
            pslverr_r <= ERR_EN & (WAIT_INIT == 4'd0) & err_s;
            if (!Pwrite) begin
                prdata_r <= in_range_s ? mem_r[idx_s] : 32'h0000_0000;
            end else begin
                prdata_r <= prdata_r;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    pready_r  <= 1'b0;
                    pslverr_r <= 1'b0;
                end
                ACCESS: begin
                    if (!sel_s) begin
                        state_r   <= IDLE;
                        pready_r  <= 1'b0;
                        pslverr_r <= 1'b0;
                    end else if (cnt_r != 4'd0) begin
                        cnt_r     <= cnt_r - 4'd1;
                        pready_r  <= (cnt_r == 4'd1);
                        pslverr_r <= ERR_EN & (cnt_r == 4'd1) & err_r;
                    end else begin
                        if (write_r && !err_r) begin
                            mem_r[idx_r] <= wdata_r;
                        end else begin
                            mem_r[idx_r] <= mem_r[idx_r];
                        end
                        state_r   <= IDLE;
                        pready_r  <= 1'b0;
                        pslverr_r <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    pready_r  <= 1'b0;
                    pslverr_r <= 1'b0;
                end
            endcase
        end
    end

    assign Prdata  = prdata_r;
    assign Pready  = pready_r;
    assign Pslverr = pslverr_r;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Scoreboard bench: three slaves share one APB bus, one per Pselx bit, with 0, 3 and 2 wait states.
module tb_apb_slave_mem;

    logic        Hclk;
    logic        Hreset;
    logic [2:0]  Pselx;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic [31:0] prdata  [3];
    logic        pready  [3];
    logic        pslverr [3];

    int passed;
    int total;

    typedef struct {
        int          slv;
        bit          rd;
        logic [31:0] rdata;
        bit          err;
    } exp_t;

    exp_t sb[$];

`ifdef APB_SLV_ERR_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    apb_slave_mem #(.SEL_INDEX(0), .WAIT_STATES(0)) dut0 (
        .Hclk(Hclk), .Hreset(Hreset), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
        .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(prdata[0]), .Pready(pready[0]), .Pslverr(pslverr[0]));

    apb_slave_mem #(.SEL_INDEX(1), .WAIT_STATES(3)) dut1 (
        .Hclk(Hclk), .Hreset(Hreset), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
        .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(prdata[1]), .Pready(pready[1]), .Pslverr(pslverr[1]));

    apb_slave_mem #(.SEL_INDEX(2), .WAIT_STATES(2)) dut2 (
        .Hclk(Hclk), .Hreset(Hreset), .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite),
        .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(prdata[2]), .Pready(pready[2]), .Pslverr(pslverr[2]));

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    // Monitor: every Pready pulse must match the oldest outstanding expectation.
    always @(negedge Hclk) begin
        exp_t e;
        if (!Hreset) begin
            for (int s = 0; s < 3; s++) begin
                if (pready[s]) begin
                    if (sb.size() == 0) begin
                        check("unexpected_ready", 32'(s), 32'hFFFF_FFFF);
                    end else begin
                        e = sb.pop_front();
                        check("responder", 32'(s), 32'(e.slv));
                        if (e.rd) check("prdata", prdata[s], e.rdata);
                        check("pslverr", {31'd0, pslverr[s]}, {31'd0, e.err});
                    end
                end
            end
        end
    end

    // One APB transfer on slave s; entered and left just after a rising edge.
    task automatic xfer(input int s, input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input bit exp_err, input int ws);
        int cycles;
        bit done;
        sb.push_back('{slv: s, rd: !wr, rdata: exp_rd, err: exp_err});
        Pselx   = 3'b001 << s;
        Pwrite  = wr;
        Paddr   = addr;
        Pwdata  = wd;
        Penable = 1'b0;
        @(posedge Hclk); #1;
        Penable = 1'b1;
        Pwdata  = ~wd;
        cycles  = 0;
        done    = 1'b0;
        while (!done && cycles < 40) begin
            @(negedge Hclk);
            cycles++;
            if (pready[s]) done = 1'b1;
        end
        check("access_cycles", 32'(cycles), 32'(ws + 1));
        @(posedge Hclk); #1;
        Pselx   = 3'b000;
        Penable = 1'b0;
    endtask

    initial begin
        passed  = 0;
        total   = 0;
        Hreset  = 1'b1;
        Pselx   = 3'b000;
        Penable = 1'b0;
        Pwrite  = 1'b0;
        Paddr   = 32'h0000_0000;
        Pwdata  = 32'h0000_0000;
        repeat (3) @(posedge Hclk);
        @(negedge Hclk);
        Hreset = 1'b0;
        check("rst_pready0", {31'd0, pready[0]}, 32'd0);
        check("rst_pready1", {31'd0, pready[1]}, 32'd0);
        check("rst_prdata0", prdata[0], 32'h0000_0000);
        check("rst_pslverr0", {31'd0, pslverr[0]}, 32'd0);
        @(posedge Hclk); #1;

        xfer(0, 1'b0, 32'h8000_000C, 32'h0, 32'h0000_0000, 1'b0, 0);
        xfer(0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0, 0);
        xfer(0, 1'b0, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);
        xfer(0, 1'b0, 32'h8000_0013, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);

        xfer(1, 1'b1, 32'h8000_0004, 32'h1234_5678, 32'h0, 1'b0, 3);
        xfer(1, 1'b0, 32'h8000_0004, 32'h0, 32'h1234_5678, 1'b0, 3);

        xfer(0, 1'b0, 32'h8000_0040, 32'h0, 32'h0000_0000, ERR_ON, 0);
        xfer(0, 1'b0, 32'h7FFF_FFFC, 32'h0, 32'h0000_0000, ERR_ON, 0);
        xfer(0, 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0000_0000, ERR_ON, 0);
        xfer(0, 1'b1, 32'h8000_0040, 32'h5555_AAAA, 32'h0, ERR_ON, 0);

        xfer(0, 1'b1, 32'h8000_003C, 32'h0BAD_F00D, 32'h0, ERR_ON, 0);
        xfer(0, 1'b0, 32'h8000_003C, 32'h0, ERR_ON ? 32'hA5A5_0010 : 32'h0BAD_F00D, 1'b0, 0);

        // ENABLE without a preceding SETUP must be ignored by slave 0.
        Pselx   = 3'b001;
        Penable = 1'b1;
        Paddr   = 32'h8000_0010;
        repeat (3) @(posedge Hclk);
        #1;
        Pselx   = 3'b000;
        Penable = 1'b0;

        // Pselx=010 belongs to slave 1; slave 0 memory must be untouched.
        xfer(1, 1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 32'h0, 1'b0, 3);
        xfer(0, 1'b0, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);
        xfer(1, 1'b0, 32'h8000_0010, 32'h0, 32'hFFFF_FFFF, 1'b0, 3);

        // Reset during the first wait state of a slave-2 write.
        Pselx   = 3'b100;
        Pwrite  = 1'b1;
        Paddr   = 32'h8000_0008;
        Pwdata  = 32'hCAFE_0001;
        Penable = 1'b0;
        @(posedge Hclk); #1;
        Penable = 1'b1;
        #2;
        Hreset = 1'b1;
        #1;
        check("midrst_pready2", {31'd0, pready[2]}, 32'd0);
        check("midrst_prdata0", prdata[0], 32'h0000_0000);
        Pselx   = 3'b000;
        Penable = 1'b0;
        @(negedge Hclk);
        Hreset = 1'b0;
        @(posedge Hclk); #1;
        xfer(2, 1'b0, 32'h8000_0008, 32'h0, 32'h0000_0000, 1'b0, 2);
        xfer(0, 1'b0, 32'h8000_0010, 32'h0, 32'h0000_0000, 1'b0, 0);

        repeat (2) @(posedge Hclk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/apb_slave_mem.md
Name: apb_slave_mem

Overview:
- APB completer (responder) at the far end of the AHB-to-APB bridge.
- Decodes one Pselx line and serves reads and writes to a small word-addressed register memory.
- Inserts a programmable number of wait states via Pready and flags bad accesses on Pslverr.
- The bench instantiates one copy per Pselx bit, behind the APB pass-through interface.

Parameters:
- SEL_INDEX, 0, which bit of Pselx selects this slave (0..2).
- BASE_ADDR, 32'h8000_0000, byte base address of the memory window; must be 4-byte aligned.
- DEPTH, 16, number of 32-bit words; power of two, 2..256.
- WAIT_STATES, 0, extra ACCESS cycles before Pready asserts (0..15).

Ports:
- Hclk  input  1  clock; all APB inputs are sampled on the rising edge.
- Hreset  input  1  asynchronous, active-high reset.
- Pselx  input  3  APB slave selects; this slave uses bit SEL_INDEX.
- Penable  input  1  APB enable (ACCESS phase).
- Pwrite  input  1  1 = write, 0 = read.
- Paddr  input  32  byte address.
- Pwdata  input  32  write data.
- Prdata  output  32  read data.
- Pready  output  1  transfer-complete indication.
- Pslverr  output  1  error response, qualified by Pready.

Behaviour:
- sel = Pselx[SEL_INDEX]. Word index idx = (Paddr - BASE_ADDR) >> 2. Paddr[1:0] is ignored.
- in_range = (Paddr >= BASE_ADDR) and (Paddr < BASE_ADDR + 4*DEPTH). Compute in 33 bits so there is no wrap at 32'hFFFF_FFFF.
- Reset (async, Hreset=1) sets:
  - state = IDLE, cnt = 0, Prdata = 0, Pready = 0, Pslverr = 0;
  - all memory words = 0;
  - latched addr/write/wdata/err = 0.
- FSM states: IDLE, ACCESS.
- IDLE:
  - Pready = 0.
  - On a rising edge with sel=1 and Penable=0 (SETUP sampled):
    - latch idx, Pwrite, Pwdata, err = !in_range;
    - cnt <= WAIT_STATES;
    - if read: Prdata <= in_range ? mem[idx] : 32'h0;
    - go to ACCESS.
  - sel=1 with Penable=1 while in IDLE (no setup seen): ignored, stay IDLE.
- ACCESS:
  - Pready = (cnt == 0). This is decoded from registered state only and is never combinational from inputs.
  - On a rising edge with sel=1, Penable=1:
    - if cnt != 0: cnt <= cnt - 1;
    - else the transfer completes: if latched write and !err, mem[idx] <= latched wdata; go to IDLE.
  - On a rising edge with sel=0 (protocol abort): go to IDLE, no memory write, Prdata unchanged.
  - sel=1, Penable=0 while in ACCESS: treat as a new SETUP, re-latch as in IDLE, stay in ACCESS.
- Latency: with WAIT_STATES=N, a transfer occupies 2+N cycles (setup, N waits, final access). Pready is high only in the final cycle.
- Write data is taken from the SETUP-phase latch. A Pwdata change during ACCESS is ignored.
- Prdata holds its last value between transfers. It is valid when Pready=1 on a read.
- Back-to-back transfers: after completion, IDLE accepts a new SETUP on the very next edge. No dead cycle is required beyond APB's own setup phase.
- Other Pselx bits are ignored completely. Multiple Pselx bits set is a master error; this slave responds only to its own bit.
- Reset asserted mid-transfer: immediate return to IDLE with Pready=0; the pending write is discarded.

Optional Feature:
- Macro: APB_SLV_ERR_EN.
- Defined:
  - Pslverr = Pready & err;
  - err is also set for writes whose latched idx equals DEPTH-1 (last word read-only, ID register, reset value 32'hA5A5_0000 | DEPTH).
- Not defined:
  - Pslverr is tied to 0;
  - out-of-range writes are silently dropped and out-of-range reads return 0;
  - the last word is ordinary RAM.

Test Plan:
- Reset, then read idx 3 (Paddr=32'h8000_000C), WAIT_STATES=0 -> Pready high on 2nd cycle, Prdata=32'h0, Pslverr=0.
- Write 32'hDEAD_BEEF to 32'h8000_0010, then read the same address -> read returns 32'hDEAD_BEEF; each transfer takes 2 cycles.
- WAIT_STATES=3, write 32'h1234_5678 to 32'h8000_0004 -> Pready low for 3 ACCESS cycles, high on the 4th; a read-back returns 32'h1234_5678.
- Read 32'h8000_0040 (out of range, DEPTH=16) -> Prdata=0. With APB_SLV_ERR_EN: Pslverr=1 with Pready. Without it: Pslverr=0.
- Pselx=3'b010 with SEL_INDEX=0, then a write of 32'hFFFF_FFFF -> Pready stays 0 and memory is unchanged on read-back.
- Start a write of 32'hCAFE_0001 with WAIT_STATES=2 and assert Hreset during the 1st wait -> Pready=0 immediately; read-back after release returns 32'h0.
